// File: rtl/subxor_issue_sched.sv
// Round-robin issue scheduler sharing one SIMD sub/xor unit between NREQ requesters.
// Results return tagged with the requester ID; a width change waits for the unit to drain.
package subxor_pkg;
    typedef logic [63:0] prng_t;
    typedef enum logic [1:0] {W8 = 2'd0, W16 = 2'd1, W32 = 2'd2, W64 = 2'd3} width_t;
    typedef struct packed {
        logic csa;
        logic b;
    } mode_t;
endpackage

module subxor_issue_sched
    import subxor_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int UNIT_LAT = 4,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [NREQ-1:0] req_valid_i,
    output logic [NREQ-1:0] req_ready_o,
    input  prng_t           req_x_i     [NREQ],
    input  prng_t           req_y_i     [NREQ],
    input  prng_t           req_ex_i    [NREQ],
    input  mode_t           req_mode_i  [NREQ],
    input  width_t          req_width_i [NREQ],
    input  logic            drain_i,
    output prng_t           unit_x_o,
    output prng_t           unit_y_o,
    output prng_t           unit_ex_o,
    output mode_t           unit_mode_o,
    output width_t          unit_width_o,
    input  prng_t           unit_z_i,
    output logic            rsp_valid_o,
    output logic [IDW-1:0]  rsp_id_o,
    output prng_t           rsp_z_o,
    output logic            idle_o
);

    localparam int CW = $clog2(UNIT_LAT + 2);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    tag_t           tag_pipe [UNIT_LAT+1];
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cand;
    logic           cand_found;
    logic           grant;
    width_t         cur_width;
    logic [CW-1:0]  inflight;

    // NOTE: every output of this block is given a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        logic [IDW-1:0] idx;
        idx         = '0;
        cand        = '0;
        cand_found  = 1'b0;
        req_ready_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!cand_found && req_valid_i[idx]) begin
                cand_found = 1'b1;
                cand       = idx;
            end
        end
        // A mismatched candidate blocks everyone behind it; that is what prevents starvation.
        grant = rst_n_i && cand_found && !drain_i &&
                (req_width_i[cand] == cur_width || inflight == '0);
        if (grant) req_ready_o[cand] = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rr_ptr      <= '0;
            cur_width   <= W8;
            unit_x_o    <= '0;
            unit_y_o    <= '0;
            unit_ex_o   <= '0;
            unit_mode_o <= '0;
            inflight    <= '0;
            // NOTE: the tag pipe is reset, not just left to flush, so ops in flight at
            // reset never produce a response.
            for (int s = 0; s <= UNIT_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: grant, id: cand};
            for (int s = 1; s <= UNIT_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];

            if (grant) begin
                rr_ptr      <= (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
                cur_width   <= req_width_i[cand];
                unit_x_o    <= req_x_i[cand];
                unit_y_o    <= req_y_i[cand];
                unit_ex_o   <= req_ex_i[cand];
                unit_mode_o <= req_mode_i[cand];
            end

            case ({grant, tag_pipe[UNIT_LAT].valid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase
        end
    end

    assign unit_width_o = cur_width;
    assign rsp_valid_o  = tag_pipe[UNIT_LAT].valid;
    assign rsp_id_o     = tag_pipe[UNIT_LAT].id;
    assign rsp_z_o      = unit_z_i;
    assign idle_o       = (inflight == '0);

endmodule

// File: doc/subxor_issue_sched.md
Name: subxor_issue_sched

Overview:
- Shares one SIMD sub/xor datapath unit between NREQ requesters in the correlated-random generation path.
- Arbitrates round-robin and registers the winning operands into the unit.
- Tags each issued op with its requester ID through a shadow pipeline matched to the unit latency, and returns the result with that ID.
- Enforces the unit's rule that width stays constant while any op is in flight: a width change is a drain bubble.

Parameters:
- NREQ, 4: number of requesters (2..8).
- UNIT_LAT, 4: cycles from unit operand inputs to a valid result on unit_z_i.
- IDW, $clog2(NREQ): requester ID width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous active-low reset.
- req_valid_i  in  NREQ  per-requester request valid.
- req_ready_o  out  NREQ  per-requester grant; one-hot or zero.
- req_x_i  in  NREQ x prng_t  minuend / xor operand.
- req_y_i  in  NREQ x prng_t  subtrahend / xor operand.
- req_ex_i  in  NREQ x prng_t  extra CSA operand.
- req_mode_i  in  NREQ x mode_t  operation mode (mode.b=1 xor, 0 sub).
- req_width_i  in  NREQ x width_t  SIMD lane width.
- drain_i  in  1  block new grants while high.
- unit_x_o, unit_y_o, unit_ex_o  out  prng_t  registered operands to the unit.
- unit_mode_o  out  mode_t  registered mode.
- unit_width_o  out  width_t  current width; held stable across in-flight ops.
- unit_z_i  in  prng_t  unit result.
- rsp_valid_o  out  1  result valid.
- rsp_id_o  out  IDW  requester ID of the result.
- rsp_z_o  out  prng_t  result; passthrough of unit_z_i.
- idle_o  out  1  no op issued or in flight.

Behaviour:
- Handshake: request i is accepted on a cycle where req_valid_i[i] && req_ready_o[i]. Requesters hold valid and operands stable until accepted.
- req_ready_o is combinational and asserts at most one bit per cycle.
- Arbitration:
  - Candidate = first valid requester scanning from rr_ptr upward, wrapping modulo NREQ.
  - Grant the candidate iff drain_i=0 and (req_width_i[cand]==cur_width or inflight==0).
  - If the candidate's width mismatches and inflight>0, grant nobody. Other requesters are not bypassed, so there is no starvation.
  - On a grant: rr_ptr <= cand+1 (mod NREQ), and cur_width <= req_width_i[cand].
- Issue stage: on a grant, capture x, y, ex and mode into the unit_*_o registers. tag_pipe[0] <= {1, cand}.
  - With no grant, the operand registers hold their values and tag_pipe[0] <= {0, x}.
- unit_width_o = cur_width register. It changes only on a grant while inflight==0.
- Tag pipe: UNIT_LAT+1 stages (issue stage plus UNIT_LAT), shifting every cycle. No stall: results carry no backpressure, and requesters must accept rsp in the cycle it is valid.
- rsp_valid_o/rsp_id_o come from the last tag stage. A request accepted in cycle T has rsp_valid_o=1 in cycle T+1+UNIT_LAT.
- rsp_z_o = unit_z_i. It is meaningful only when rsp_valid_o=1.
- inflight counter, width $clog2(UNIT_LAT+2):
  - +1 on grant, -1 on rsp_valid_o.
  - On a simultaneous grant and rsp it is unchanged.
  - It never exceeds UNIT_LAT+1.
- idle_o = (inflight==0).
- Back-to-back issue: one op per cycle when widths match. Full throughput is 1/cycle.
- drain_i: grants stop in the same cycle; in-flight ops complete normally. Deasserting drain_i resumes arbitration from the unchanged rr_ptr.
- Reset values (rst_n_i=0 at a clock edge):
  - Cleared: all tag valid bits, inflight, rr_ptr, cur_width, unit_*_o operand registers, rsp_valid_o, rsp_id_o.
  - idle_o=1.
  - req_ready_o=0 while rst_n_i=0.
  - In-flight ops are discarded: no rsp is produced for them after reset. The unit is reset by the same rst_n_i.

Test Plan:
- Single request: req0 sub, x=0x10, y=0x3, width=32-bit, UNIT_LAT=4, accepted at T -> rsp_valid_o=1 at T+5, rsp_id_o=0, rsp_z_o equals the unit result; idle_o=0 for T+1..T+5, and 1 at T+6.
- Round-robin: all 4 requesters valid, same width, continuously -> grants 0,1,2,3,0,... on consecutive cycles; rsp IDs follow the same order 5 cycles later; inflight saturates at 5.
- Width switch: req0 width A granted at T, req1 width B valid from T+1 -> no grant T+1..T+5; req1 granted at T+6, once inflight=0; unit_width_o stable at A until T+6.
- No bypass: rr_ptr at 1, req1 mismatched width while busy, req2 matching -> req2 not granted until req1 is granted.
- drain_i high with 3 ops in flight -> no new grants; 3 rsp pulses still arrive; idle_o rises after the last one; drain low -> arbitration resumes from the saved rr_ptr.
- Reset with 3 ops in flight -> no rsp_valid_o afterward; outputs at reset values; the first post-reset grant goes to the lowest-index valid requester.
